// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the ReLU/requantise/saturate helper
// used by every post-processing stage.
package cnn_pkg;

  localparam int DEF_PSUM_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_OUT_WIDTH  = 8;

  // Operates on a sign-extended 64-bit value so any accumulator/output width
  // pair can share it; callers cast the result down to their output width.
  function automatic logic [63:0] relu_sat(input logic signed [63:0] val,
                                           input int unsigned        shift,
                                           input int unsigned        out_w);
    logic [63:0] r;
    logic [63:0] max_v;
    max_v = (64'd1 << out_w) - 64'd1;
    if (val < 0) begin
      r = '0;
    end else begin
      r = val >>> shift;
    end
    return (r > max_v) ? max_v : r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// FWFT FIFO: rd_data shows the head combinationally, a write lands one edge later.
// Write when full is accepted only if a read happens in the same cycle; otherwise ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage is cleared too so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_wr && !do_rd) begin
        count <= count + 1'b1;
      end else if (!do_wr && do_rd) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Sums NUM_CH partial sums, then ReLU/shift/saturate into an FWFT FIFO; 2 cycles last strobe to out_vld.
// Input never stalls: a result arriving at a full FIFO without a pop is dropped and sets sticky overflow.
module psum_accumulator
  import cnn_pkg::*;
#(
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int NUM_CH     = 4,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [PSUM_WIDTH-1:0] in_psum,
  input  logic                         in_psum_vld,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic                         overflow,
  output logic                         busy
);

  localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] psum_ext;
  logic [CNT_W-1:0]            ch_cnt;
  logic [CNT_W-1:0]            ch_cnt_nxt;
  logic                        last_q;
  logic                        last_nxt;
  logic                        overflow_q;
  logic                        busy_q;
  logic [OUT_WIDTH-1:0]        res;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        pop;
  logic                        drop;

  assign psum_ext = ACC_WIDTH'(in_psum);

  always_comb begin
    ch_cnt_nxt = ch_cnt;
    last_nxt   = 1'b0;
    if (in_psum_vld) begin
      if (ch_cnt == LAST_CH) begin
        ch_cnt_nxt = '0;
        last_nxt   = 1'b1;
      end else begin
        ch_cnt_nxt = ch_cnt + 1'b1;
      end
    end
  end

  // acc still holds the finished group while last_q is high, even if the
  // next group's first psum overwrites it on the same edge as the push.
  assign res  = OUT_WIDTH'(relu_sat(64'(acc), SHIFT, OUT_WIDTH));
  assign pop  = out_rdy && !fifo_empty;
  assign drop = last_q && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      ch_cnt     <= '0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (in_psum_vld) begin
        acc <= (ch_cnt == '0) ? psum_ext : acc + psum_ext;
      end
      ch_cnt     <= ch_cnt_nxt;
      last_q     <= last_nxt;
      overflow_q <= overflow_q | drop;
      busy_q     <= (ch_cnt_nxt != '0) | last_nxt;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (last_q),
    .wr_data (res),
    .full    (fifo_full),
    .rd_en   (out_rdy),
    .rd_data (out_data),
    .empty   (fifo_empty)
  );

  assign out_vld  = !fifo_empty;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: vector table of four-psum groups plus
// hand-written sequences for latency, sparse strobes, overflow, push-at-full and reset.
module tb_psum_accumulator;

  logic              clk;
  logic              rst;
  logic signed [15:0] in_psum;
  logic              in_psum_vld;
  logic [7:0]        out_data;
  logic              out_vld;
  logic              out_rdy;
  logic              overflow;
  logic              busy;

  psum_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .in_psum     (in_psum),
    .in_psum_vld (in_psum_vld),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p [4];
    int exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  int   exp_q [$];
  int   n_cmp;
  int   n_err;
  int   pops;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scores any pop about to happen at the coming edge, then advances one cycle.
  task automatic tick();
    if (out_vld && out_rdy) begin
      pops++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got %0d, expected no output (t=%0t)", out_data, $time);
      end else begin
        check("pop_data", int'(out_data), exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int v);
    in_psum     = 16'(v);
    in_psum_vld = 1'b1;
    tick();
  endtask

  task automatic send_group(input int a, input int b, input int c, input int d);
    strobe(a);
    strobe(b);
    strobe(c);
    strobe(d);
  endtask

  task automatic set_vec(input int i, input int a, input int b, input int c,
                         input int d, input int e);
    vecs[i].p[0] = a;
    vecs[i].p[1] = b;
    vecs[i].p[2] = c;
    vecs[i].p[3] = d;
    vecs[i].exp  = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    pops  = 0;
    set_vec(0,    100,    200,    300,    400,  62);
    set_vec(1,    -50,    -50,     10,     20,   0);
    set_vec(2,   2000,   2000,   2000,   2000, 255);
    set_vec(3,     16,     16,     16,     16,   4);
    set_vec(4,      0,      0,      0,      0,   0);
    set_vec(5,     15,      0,      0,      0,   0);
    set_vec(6,     16,      0,      0,      0,   1);
    set_vec(7,   4095,      1,      0,      0, 255);
    set_vec(8,   4080,      0,      0,      0, 255);
    set_vec(9,   4079,      0,      0,      0, 254);
    set_vec(10, 32767, -32768,     17,      0,   1);
    set_vec(11,-32768, -32768, -32768, -32768,   0);
    set_vec(12, 32767,  32767,  32767,  32767, 255);
    set_vec(13,    -1,      0,      0,     16,   0);

    rst         = 1'b1;
    in_psum     = '0;
    in_psum_vld = 1'b0;
    out_rdy     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_vld",  int'(out_vld),  0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_busy",     int'(busy),     0);
    check("rst_out_data", int'(out_data), 0);
    rst = 1'b0;
    tick();

    // Per-group latency and busy profile, one group at a time.
    for (int v = 0; v < NV; v++) begin
      strobe(vecs[v].p[0]);
      check("busy_first", int'(busy), 1);
      strobe(vecs[v].p[1]);
      strobe(vecs[v].p[2]);
      strobe(vecs[v].p[3]);
      in_psum_vld = 1'b0;
      check("lat_t0_vld", int'(out_vld), 0);
      check("lat_t0_busy", int'(busy), 1);
      exp_q.push_back(vecs[v].exp);
      tick();
      check("lat_t1_vld", int'(out_vld), 1);
      check("lat_t1_data", int'(out_data), vecs[v].exp);
      check("lat_t1_busy", int'(busy), 0);
      tick();
      check("lat_t2_vld", int'(out_vld), 0);
    end
    check("tbl_drained", exp_q.size(), 0);

    // Same table streamed with no idle cycles between groups.
    for (int v = 0; v < NV; v++) exp_q.push_back(vecs[v].exp);
    for (int v = 0; v < NV; v++) begin
      send_group(vecs[v].p[0], vecs[v].p[1], vecs[v].p[2], vecs[v].p[3]);
    end
    in_psum_vld = 1'b0;
    repeat (4) tick();
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_overflow", int'(overflow), 0);

    // Sparse strobes: 1-on/1-off, sum 16 -> 1.
    exp_q.push_back(1);
    begin
      int sp [4];
      sp = '{1, 2, 3, 10};
      for (int i = 0; i < 4; i++) begin
        strobe(sp[i]);
        check("sparse_busy_on", int'(busy), 1);
        in_psum_vld = 1'b0;
        if (i < 3) begin
          tick();
          check("sparse_busy_off", int'(busy), 1);
          check("sparse_no_out", int'(out_vld), 0);
        end
      end
    end
    tick();
    check("sparse_busy_done", int'(busy), 0);
    check("sparse_vld", int'(out_vld), 1);
    check("sparse_data", int'(out_data), 1);
    repeat (3) tick();
    check("sparse_single", int'(out_vld), 0);
    check("sparse_drained", exp_q.size(), 0);

    // Fill with out_rdy low; the ninth result must be dropped.
    out_rdy = 1'b0;
    for (int g = 0; g < 9; g++) begin
      send_group(16, 16, 16, 16);
      if (g < 8) exp_q.push_back(4);
    end
    in_psum_vld = 1'b0;
    check("ovf_before", int'(overflow), 0);
    check("ovf_full_vld", int'(out_vld), 1);
    tick();
    check("ovf_rise", int'(overflow), 1);
    out_rdy = 1'b1;
    pops    = 0;
    repeat (8) tick();
    check("ovf_drain_cnt", pops, 8);
    check("ovf_empty", int'(out_vld), 0);
    check("ovf_sticky", int'(overflow), 1);
    repeat (2) tick();
    check("ovf_no_extra", pops, 8);

    // Reset in the middle of a group discards the partial sum.
    strobe(500);
    strobe(500);
    in_psum_vld = 1'b0;
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_vld",  int'(out_vld),  0);
    check("mid_rst_ovf",  int'(overflow), 0);
    check("mid_rst_busy", int'(busy),     0);
    check("mid_rst_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_post_busy", int'(busy), 0);
    exp_q.push_back(4);
    pops = 0;
    send_group(16, 16, 16, 16);
    in_psum_vld = 1'b0;
    repeat (4) tick();
    check("mid_one_out", pops, 1);
    check("mid_drained", exp_q.size(), 0);

    // Push coinciding with a pop while full: nothing is lost.
    out_rdy = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      send_group(4 * k, 4 * k, 4 * k, 4 * k);
      exp_q.push_back(k);
    end
    in_psum_vld = 1'b0;
    check("pwp_full_vld", int'(out_vld), 1);
    out_rdy = 1'b1;
    tick();
    check("pwp_no_drop", int'(overflow), 0);
    check("pwp_head", int'(out_data), 2);
    pops = 0;
    repeat (8) tick();
    check("pwp_drain_cnt", pops, 8);
    check("pwp_empty", int'(out_vld), 0);
    check("pwp_drained", exp_q.size(), 0);
    check("pwp_ovf_final", int'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
